// File: rtl/chrono_pkg.sv
// Shared defaults and recall FSM encoding for the chronometer lap-memory blocks.
package chrono_pkg;

    localparam int RAM_WIDTH_DEF     = 16;
    localparam int RAM_ADDR_BITS_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } recall_state_t;

endpackage

// File: rtl/lap_cursor.sv
// Browse cursor for the lap ring: holds the cursor index, applies next/prev wrap,
// and converts the selected index into a BRAM address relative to the oldest lap.
module lap_cursor
    import chrono_pkg::*;
#(
    parameter int ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic                 dir_next,
    input  logic [ADDR_BITS:0]   lap_count,
    input  logic [ADDR_BITS-1:0] wp,
    output logic [ADDR_BITS-1:0] sel_addr
);

    logic [ADDR_BITS-1:0] cursor;
    logic [ADDR_BITS-1:0] cursor_nxt;
    logic [ADDR_BITS-1:0] last;
    logic [ADDR_BITS-1:0] oldest;
    logic                 has_cursor;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        // A full ring has lap_count low bits of 0, so the truncated subtraction still yields DEPTH-1.
        last       = ADDR_BITS'(lap_count - 1'b1);
        cursor_nxt = cursor;
        if (!has_cursor) begin
            cursor_nxt = dir_next ? '0 : last;
        end else if (dir_next) begin
            cursor_nxt = (cursor == last) ? '0 : cursor + ADDR_BITS'(1);
        end else begin
            cursor_nxt = (cursor == '0) ? last : cursor - ADDR_BITS'(1);
        end
        oldest   = wp - ADDR_BITS'(lap_count);
        sel_addr = oldest + cursor_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor     <= '0;
            has_cursor <= 1'b0;
        end else if (clear) begin
            cursor     <= '0;
            has_cursor <= 1'b0;
        end else if (step) begin
            cursor     <= cursor_nxt;
            has_cursor <= 1'b1;
        end
    end

endmodule

// File: rtl/lap_record_ctrl.sv
// Lap-memory controller: records lap times into a circular BRAM and recalls them
// through the registered read port, hiding its one-cycle latency behind a small FSM.
module lap_record_ctrl
    import chrono_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RAM_WIDTH-1:0]     time_in,
    input  logic                     lap_strobe,
    input  logic                     clear,
    input  logic                     recall_next,
    input  logic                     recall_prev,
    output logic [RAM_ADDR_BITS-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0]     wr_data,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]     rd_data,
    output logic [RAM_WIDTH-1:0]     lap_time,
    output logic                     lap_valid,
    output logic [RAM_ADDR_BITS:0]   lap_count,
    output logic                     wrapped,
    output logic                     busy
);

    localparam int                   DEPTH = 2 ** RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS:0] FULL = (RAM_ADDR_BITS + 1)'(DEPTH);

    recall_state_t            state, state_nxt;
    logic [RAM_ADDR_BITS-1:0] wp;
    logic [RAM_ADDR_BITS-1:0] sel_addr;
    logic                     req_ok;
    logic                     step;
    logic                     full;
    logic                     hit_rd;
    logic                     bypass_pend;
    logic [RAM_WIDTH-1:0]     bypass_data;

    assign full   = (lap_count == FULL);
    assign hit_rd = write_enable && (wr_addr == rd_addr);
    assign busy   = (state != IDLE);

    // Simultaneous next+prev is ambiguous and therefore dropped.
    always_comb begin
        req_ok    = (recall_next ^ recall_prev) && (lap_count != '0) && !clear;
        state_nxt = state;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    step      = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    lap_cursor #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .step      (step),
        .dir_next  (recall_next),
        .lap_count (lap_count),
        .wp        (wp),
        .sel_addr  (sel_addr)
    );

    // Write path: clear has priority over a simultaneous strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp           <= '0;
            lap_count    <= '0;
            wrapped      <= 1'b0;
            write_enable <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            write_enable <= 1'b0;
            if (clear) begin
                wp        <= '0;
                lap_count <= '0;
                wrapped   <= 1'b0;
            end else if (lap_strobe) begin
                write_enable <= 1'b1;
                wr_addr      <= wp;
                wr_data      <= time_in;
                wp           <= wp + RAM_ADDR_BITS'(1);
                if (full) begin
                    wrapped <= 1'b1;
                end else begin
                    lap_count <= lap_count + 1'b1;
                end
            end
        end
    end

    // A write landing on rd_addr during ADDR commits with the read (read-first BRAM returns
    // stale data), and one during DATA lands too late; both are forwarded into lap_time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr     <= '0;
            lap_time    <= '0;
            lap_valid   <= 1'b0;
            bypass_pend <= 1'b0;
            bypass_data <= '0;
        end else begin
            if (step) begin
                rd_addr <= sel_addr;
            end
            if (state == ADDR) begin
                bypass_pend <= hit_rd;
                bypass_data <= wr_data;
            end
            if (clear) begin
                lap_valid <= 1'b0;
            end else if (state == DATA) begin
                lap_valid <= 1'b1;
                if (hit_rd) begin
                    lap_time <= wr_data;
                end else if (bypass_pend) begin
                    lap_time <= bypass_data;
                end else begin
                    lap_time <= rd_data;
                end
            end else if (state == IDLE && hit_rd) begin
                // The displayed slot was overwritten by a newer lap.
                lap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lap_record_ctrl.sv
// Directed bench for lap_record_ctrl at DEPTH=4 with a read-first registered BRAM model.
module tb_lap_record_ctrl;

    localparam int W = 16;
    localparam int A = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] time_in = '0;
    logic         lap_strobe = 1'b0;
    logic         clear = 1'b0;
    logic         recall_next = 1'b0;
    logic         recall_prev = 1'b0;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         write_enable;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic [W-1:0] lap_time;
    logic         lap_valid;
    logic [A:0]   lap_count;
    logic         wrapped;
    logic         busy;

    int tests = 0;
    int failed = 0;

    logic [W-1:0] mem [4];

    lap_record_ctrl #(
        .RAM_WIDTH     (W),
        .RAM_ADDR_BITS (A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .time_in      (time_in),
        .lap_strobe   (lap_strobe),
        .clear        (clear),
        .recall_next  (recall_next),
        .recall_prev  (recall_prev),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .write_enable (write_enable),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .lap_time     (lap_time),
        .lap_valid    (lap_valid),
        .lap_count    (lap_count),
        .wrapped      (wrapped),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    typedef struct {
        logic [W-1:0] t;
        logic         strobe;
        logic         clr;
        logic         exp_we;
        logic [A-1:0] exp_wa;
        logic [W-1:0] exp_wd;
        logic [A:0]   exp_cnt;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            time_in    = vecs[i].t;
            lap_strobe = vecs[i].strobe;
            clear      = vecs[i].clr;
            tick();
            lap_strobe = 1'b0;
            clear      = 1'b0;
            check($sformatf("vec%0d we", i), write_enable, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d wr_addr", i), wr_addr, vecs[i].exp_wa);
                check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].exp_wd);
            end
            check($sformatf("vec%0d lap_count", i), lap_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d wrapped", i), wrapped, vecs[i].exp_wrap);
        end
    endtask

    task automatic recall(input string name, input logic nxt, input logic [A-1:0] exp_addr,
                          input logic [W-1:0] exp_time);
        recall_next = nxt;
        recall_prev = !nxt;
        tick();
        recall_next = 1'b0;
        recall_prev = 1'b0;
        check({name, " rd_addr"}, rd_addr, exp_addr);
        check({name, " busy"}, busy, 1'b1);
        tick();
        tick();
        check({name, " lap_time"}, lap_time, exp_time);
        check({name, " lap_valid"}, lap_valid, 1'b1);
        check({name, " busy done"}, busy, 1'b0);
    endtask

    task automatic strobe(input logic [W-1:0] t);
        time_in    = t;
        lap_strobe = 1'b1;
        tick();
        lap_strobe = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        //          t        stb   clr   we    wa    wd       cnt   wrap
        vecs[0]  = '{16'h0011, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0011, 3'd1, 1'b0};
        vecs[1]  = '{16'h0022, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0022, 3'd2, 1'b0};
        vecs[2]  = '{16'h0033, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0033, 3'd3, 1'b0};
        vecs[3]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 3'd3, 1'b0};
        vecs[4]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 3'd0, 1'b0};
        vecs[5]  = '{16'h0001, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0001, 3'd1, 1'b0};
        vecs[6]  = '{16'h0002, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0002, 3'd2, 1'b0};
        vecs[7]  = '{16'h0003, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0003, 3'd3, 1'b0};
        vecs[8]  = '{16'h0004, 1'b1, 1'b0, 1'b1, 2'd3, 16'h0004, 3'd4, 1'b0};
        vecs[9]  = '{16'h0005, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0005, 3'd4, 1'b1};
        vecs[10] = '{16'h0006, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0006, 3'd4, 1'b1};
        vecs[11] = '{16'h0077, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 3'd0, 1'b0};

        // Reset state.
        tick();
        tick();
        check("rst lap_count", lap_count, 0);
        check("rst lap_valid", lap_valid, 0);
        check("rst lap_time", lap_time, 0);
        check("rst busy", busy, 0);
        check("rst write_enable", write_enable, 0);
        check("rst wrapped", wrapped, 0);
        check("rst rd_addr", rd_addr, 0);
        rst = 1'b1;

        // Three laps, then browse forward with wrap.
        run_vecs(0, 3);
        recall("next1", 1'b1, 2'd0, 16'h0011);
        recall("next2", 1'b1, 2'd1, 16'h0022);
        recall("next3", 1'b1, 2'd2, 16'h0033);
        recall("next4", 1'b1, 2'd0, 16'h0011);

        // Recall while busy is dropped: only one step forward.
        recall_next = 1'b1;
        tick();
        tick();
        recall_next = 1'b0;
        tick();
        check("busy-ignore lap_time", lap_time, 16'h0022);
        check("busy-ignore idle", busy, 0);
        recall("after-busy", 1'b1, 2'd2, 16'h0033);

        // next+prev together is dropped.
        recall_next = 1'b1;
        recall_prev = 1'b1;
        tick();
        recall_next = 1'b0;
        recall_prev = 1'b0;
        check("both busy", busy, 0);
        tick();
        tick();
        check("both lap_time", lap_time, 16'h0033);

        // Clear, then a recall on an empty ring is ignored.
        run_vecs(4, 4);
        recall_next = 1'b1;
        tick();
        recall_next = 1'b0;
        check("empty busy", busy, 0);
        tick();
        tick();
        check("empty lap_valid", lap_valid, 0);

        // Six laps into four slots, newest via prev from a fresh cursor.
        run_vecs(5, 10);
        recall("prev-newest", 1'b0, 2'd1, 16'h0006);

        // Write landing on the slot being read in DATA is forwarded.
        recall_next = 1'b1;
        tick();
        recall_next = 1'b0;
        check("bypass rd_addr", rd_addr, 2'd2);
        strobe(16'h00AA);
        check("bypass we", write_enable, 1);
        check("bypass wr_addr", wr_addr, 2'd2);
        tick();
        check("bypass lap_time", lap_time, 16'h00AA);
        check("bypass lap_valid", lap_valid, 1);

        // Overwriting the displayed slot invalidates it.
        strobe(16'h00B1);
        strobe(16'h00B2);
        strobe(16'h00B3);
        tick();
        check("ovw pre lap_valid", lap_valid, 1);
        strobe(16'h00B4);
        check("ovw wr_addr", wr_addr, 2'd2);
        tick();
        check("ovw lap_valid", lap_valid, 0);
        check("ovw lap_count", lap_count, 4);

        // Clear beats a simultaneous strobe.
        run_vecs(11, 11);

        // Reset in the middle of a fetch aborts it.
        strobe(16'h0044);
        tick();
        recall_next = 1'b1;
        tick();
        recall_next = 1'b0;
        check("midrst busy pre", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst lap_valid", lap_valid, 0);
        check("midrst lap_time", lap_time, 0);
        check("midrst lap_count", lap_count, 0);
        check("midrst rd_addr", rd_addr, 0);
        check("midrst write_enable", write_enable, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("postrst lap_valid", lap_valid, 0);
        check("postrst busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
